// File: rtl/data_memory.sv
// Data memory responder for the execute-stage request port.
// Synchronous-read RAM with byte-lane stores and right-justified load data.
module data_memory #(
   parameter int    DEPTH_WORDS = 4096,
   parameter int    ADDR_BITS   = 12,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        write_i,
   input  logic [1:0]  width_i,
   output logic [31:0] rdata_o,
   output logic        misalign_o,
   output logic        store_drop_o
);

   logic [31:0]          mem [0:DEPTH_WORDS-1];
   logic [ADDR_BITS-1:0] idx;
   logic [1:0]           off;
   logic                 mis;
   logic                 we;
   logic [3:0]           be;
   logic [31:0]          wdata_sh;

   logic [31:0]          rd_q;
   logic [1:0]           off_q;
   logic [1:0]           width_q;
   logic                 mis_q;
   logic                 drop_q;
   logic [31:0]          shifted;
   logic                 unused_addr;

   // Upper address bits alias onto the array; no range fault exists.
   assign idx         = addr_i[ADDR_BITS+1:2];
   assign off         = addr_i[1:0];
   assign unused_addr = ^addr_i[31:ADDR_BITS+2];

   always_comb begin
      mis = 1'b0;
      unique case (width_i)
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b1;
      endcase
   end

   always_comb begin
      be = 4'b0000;
      unique case (width_i)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign wdata_sh = wdata_i << {off, 3'b000};
   assign we       = req_en_i & write_i & ~mis & ~rst;

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we && be[b]) begin
            mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   // Store cycles also capture the pre-write word, so rdata_o always
   // reflects the last accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= '0;
         off_q   <= '0;
         width_q <= '0;
         mis_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= req_en_i & write_i & mis;
         if (req_en_i) begin
            rd_q    <= mem[idx];
            off_q   <= off;
            width_q <= width_i;
            mis_q   <= mis;
         end
      end
   end

   assign shifted = rd_q >> {off_q, 3'b000};

   always_comb begin
      rdata_o = shifted;
      if (!mis_q) begin
         unique case (width_q)
            2'b00:   rdata_o = {24'h0, shifted[7:0]};
            2'b01:   rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = shifted;
         endcase
      end
   end

   assign misalign_o   = mis_q;
   assign store_drop_o = drop_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: scoreboarded loads, lane stores, stalls,
// misaligned drops, aliasing and reset with a pending store.
module tb_data_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_en_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        write_i;
   logic [1:0]  width_i;
   logic [31:0] rdata_o;
   logic        misalign_o;
   logic        store_drop_o;

   int n_run  = 0;
   int n_fail = 0;

   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   data_memory #(
      .DEPTH_WORDS(4096),
      .ADDR_BITS  (12),
      .INIT_FILE  ("")
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_en_i    (req_en_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .write_i     (write_i),
      .width_i     (width_i),
      .rdata_o     (rdata_o),
      .misalign_o  (misalign_o),
      .store_drop_o(store_drop_o)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_run++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %08h want %08h", tag, got, want);
      end
   endtask

   // One request cycle: drive, take the edge, land #1 after it.
   task automatic cyc(input logic en, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] w);
      req_en_i = en;
      write_i  = we;
      addr_i   = a;
      wdata_i  = d;
      width_i  = w;
      @(posedge clk);
      #1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] w, input logic drop, input string tag);
      cyc(1'b1, 1'b1, a, d, w);
      check({tag, "_drop"}, {31'h0, store_drop_o}, {31'h0, drop});
      check({tag, "_mis"}, {31'h0, misalign_o}, {31'h0, drop});
   endtask

   task automatic ld(input logic [31:0] a, input logic [1:0] w,
                     input logic [31:0] want, input logic mis,
                     input string tag);
      exp_q.push_back(want);
      cyc(1'b1, 1'b0, a, 32'h0, w);
      check(tag, rdata_o, exp_q.pop_front());
      check({tag, "_mis"}, {31'h0, misalign_o}, {31'h0, mis});
   endtask

   initial begin
      rst = 1'b1;
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_mis", {31'h0, misalign_o}, 32'h0);
      check("rst_drop", {31'h0, store_drop_o}, 32'h0);
      rst = 1'b0;

      st(32'h100, 32'hDEADBEEF, 2'b10, 1'b0, "st_word");
      ld(32'h100, 2'b10, 32'hDEADBEEF, 1'b0, "ld_word");

      st(32'h102, 32'h00000055, 2'b00, 1'b0, "st_byte");
      ld(32'h100, 2'b10, 32'hDE55BEEF, 1'b0, "ld_lane_word");
      ld(32'h102, 2'b01, 32'h0000DE55, 1'b0, "ld_half_hi");
      ld(32'h100, 2'b01, 32'h0000BEEF, 1'b0, "ld_half_lo");
      ld(32'h103, 2'b00, 32'h000000DE, 1'b0, "ld_byte3");
      ld(32'h101, 2'b00, 32'h000000BE, 1'b0, "ld_byte1");

      st(32'h101, 32'h12345678, 2'b10, 1'b1, "st_misw");
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      check("drop_pulse_end", {31'h0, store_drop_o}, 32'h0);
      ld(32'h100, 2'b10, 32'hDE55BEEF, 1'b0, "ld_after_misw");
      st(32'h100, 32'h00000000, 2'b11, 1'b1, "st_w11");
      ld(32'h100, 2'b10, 32'hDE55BEEF, 1'b0, "ld_after_w11");
      ld(32'h101, 2'b01, 32'h00DE55BE, 1'b1, "ld_mis_half");

      ld(32'h100, 2'b10, 32'hDE55BEEF, 1'b0, "ld_pre_stall");
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, (i % 2) ? 32'h104 : 32'h100, 32'hFFFFFFFF,
             2'b10);
         check("stall_rdata", rdata_o, 32'hDE55BEEF);
         check("stall_drop", {31'h0, store_drop_o}, 32'h0);
      end
      ld(32'h100, 2'b10, 32'hDE55BEEF, 1'b0, "ld_post_stall");

      st(32'h200, 32'hA5A5A5A5, 2'b10, 1'b0, "st_b2b");
      ld(32'h200, 2'b10, 32'hA5A5A5A5, 1'b0, "ld_b2b");
      ld(32'h200 + 4 * 4096, 2'b10, 32'hA5A5A5A5, 1'b0, "ld_alias");
      cyc(1'b1, 1'b1, 32'h200, 32'h11111111, 2'b10);
      check("st_prewrite", rdata_o, 32'hA5A5A5A5);
      ld(32'h200, 2'b10, 32'h11111111, 1'b0, "ld_overwrite");

      st(32'h300, 32'hCAFEF00D, 2'b10, 1'b0, "st_pre_rst");
      ld(32'h300, 2'b10, 32'hCAFEF00D, 1'b1 & 1'b0, "ld_pre_rst");
      st(32'h101, 32'h0, 2'b10, 1'b1, "st_mis_pre_rst");
      rst = 1'b1;
      cyc(1'b1, 1'b1, 32'h300, 32'h00000000, 2'b10);
      rst = 1'b0;
      check("rst2_rdata", rdata_o, 32'h0);
      check("rst2_mis", {31'h0, misalign_o}, 32'h0);
      check("rst2_drop", {31'h0, store_drop_o}, 32'h0);
      ld(32'h300, 2'b10, 32'hCAFEF00D, 1'b0, "ld_post_rst");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
